apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB initiator that converts a simple valid/ready command interface into APB SETUP/ACCESS transfers and returns read data and error status on a valid/ready response interface. It drives the peripheral register bus (control, timer and status registers at 0x0/0x4/0x8/0xC) from a CPU-side or test-sequencer-side requester. It supports slaves that have no PREADY by tying `pready` to 1.

## Interface
- `ADDR_W`, default 32, APB address width.
- `DATA_W`, default 32, APB data width.
- `TIMEOUT_CYCLES`, default 16, maximum ACCESS cycles to wait for `pready`; 0 disables the timeout.

- `pclk`  in  1  clock; all logic rises on the positive edge.
- `presetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_W  transfer address.
- `cmd_wdata`  in  DATA_W  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  DATA_W  read data; 0 for writes and for timeouts.
- `rsp_err`  out  1  `pslverr` seen or timeout.
- `paddr`  out  ADDR_W; `pwdata`  out  DATA_W; `pwrite`  out  1; `psel`  out  1; `penable`  out  1: APB request.
- `prdata`  in  DATA_W; `pready`  in  1; `pslverr`  in  1: APB completion.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: register addr, wdata and write into `paddr`/`pwdata`/`pwrite`, then go to SETUP.
- SETUP: `psel`=1, `penable`=0, for exactly one cycle. Then go to ACCESS.
- ACCESS: `psel`=1, `penable`=1. When `pready`=1 at the edge:
  - capture `prdata` (reads only; writes load 0) into `rsp_rdata`;
  - capture `pslverr` into `rsp_err`;
  - go to RESP.
- Timeout: a counter of ceil(log2(TIMEOUT_CYCLES+1)) bits counts ACCESS cycles with `pready`=0.
  - If the TIMEOUT_CYCLES-th ACCESS cycle ends with `pready`=0, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
  - The counter clears on entry to SETUP.
- RESP: `rsp_valid`=1, and `psel`/`penable` are 0. On `rsp_ready`=1, go to IDLE.
- `cmd_ready`=0 in SETUP, ACCESS and RESP. There is exactly one transfer outstanding, with no queueing.
- `paddr`, `pwdata` and `pwrite` are stable from SETUP through the end of ACCESS. After the transfer they hold their last values.
- `pready`/`pslverr` are sampled only in ACCESS and ignored elsewhere. `prdata` is ignored for writes.
- `rsp_rdata`/`rsp_err` are stable while `rsp_valid`=1.

## Timing
- Reset values (asynchronous): `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE.
  - `cmd_ready` is combinational from state, so it reads 1 once in IDLE.
  - No handshake is honored while `presetn`=0.
- Zero-wait latency:
  - edge 0: command accepted;
  - cycle 1: SETUP;
  - cycle 2: ACCESS;
  - cycle 3: RESP with `rsp_valid`=1.
- With `rsp_ready` held 1, the next `cmd_ready` is in cycle 4. Minimum throughput is 4 cycles per transfer.
- Each wait state adds one ACCESS cycle. A timeout gives a maximum of TIMEOUT_CYCLES ACCESS cycles.
- Reset asserted mid-transfer: the bus drops to idle (`psel`=0, `penable`=0) immediately. The transfer is lost, and no response is produced.
- `pready` and `pslverr` both 1 on the completion edge: the transfer completes with `rsp_err`=1.
- `pready`=1 on the timeout edge: normal completion takes priority over timeout.

## Structure
- Shared package `apb_pkg` holds:
  - the state enum typedef (IDLE, SETUP, ACCESS, RESP);
  - register-offset constants CTL_ADDR=0x0, TIMER0_ADDR=0x4, TIMER1_ADDR=0x8, STAT_ADDR=0xC, used by the bench and requesters.
- No sub-module. A single FSM plus a timeout counter is the natural partition.

## Test plan
- After reset, read 0x4 against the register slave with `pready` tied 1 -> `rsp_rdata`=0xcafe_1234, `rsp_err`=0, `rsp_valid` in cycle 3.
- Write 0x8 = 0x1234_5678, then read 0x8 -> the read returns 0x1234_5678. During the write, `psel`=1/`penable`=0 then `psel`=1/`penable`=1 with `pwdata`=0x1234_5678 stable.
- Read with `pready` low for 3 ACCESS cycles -> exactly 4 ACCESS cycles, with `paddr` stable throughout.
- `pready` held 0 with TIMEOUT_CYCLES=16 -> `psel` drops after 16 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0.
- Read with `pslverr`=1 together with `pready` -> `rsp_err`=1. Hold `rsp_ready`=0 for 5 cycles -> response held, `cmd_ready`=0 throughout.
- Assert `presetn`=0 during ACCESS -> `psel`/`penable`/`rsp_valid` go 0 asynchronously. After release, `cmd_ready`=1 and the next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state encoding and the peripheral register map.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] CTL_ADDR    = 32'h0;
  localparam logic [31:0] TIMER0_ADDR = 32'h4;
  localparam logic [31:0] TIMER1_ADDR = 32'h8;
  localparam logic [31:0] STAT_ADDR   = 32'hC;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: valid/ready command in, SETUP/ACCESS on the bus,
// valid/ready response out, with an optional ACCESS-phase timeout.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  apb_state_e       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // Gated by presetn so no command handshake can complete while reset is held.
  assign cmd_ready   = (state == IDLE) && presetn;
  assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            paddr    <= cmd_addr;
            pwdata   <= cmd_wdata;
            pwrite   <= cmd_write;
            psel     <= 1'b1;
            penable  <= 1'b0;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // Completion wins over a timeout landing on the same edge.
          if (pready) begin
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timeout_hit) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed and randomized transfers against a register-slave
// model, with the expected results predicted from the transfer-level rules.
module tb_apb_master;
  import apb_pkg::*;

  localparam int TO = 16;

  logic        pclk, presetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;

  int tests = 0;
  int fails = 0;

  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Register slave: wait_req wait states per ACCESS, err_req drives pslverr.
  logic [31:0] mem [4];
  int          acc_cnt;
  int          wait_req;
  bit          err_req;

  assign pready  = (psel && penable) ? (acc_cnt >= wait_req) : 1'b1;
  assign pslverr = err_req;
  assign prdata  = pwrite ? 32'hdead_beef : mem[paddr[3:2]];

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else if (!psel) acc_cnt <= 0;
    if (presetn && psel && penable && pready && pwrite) mem[paddr[3:2]] <= pwdata;
  end

  logic [31:0] model [4];
  logic [31:0] addr_map [4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_xfer(input bit wr, input int idx, input logic [31:0] wdata,
                         input int waits, input bit slverr, input int hold);
    bit          timeout;
    int          acc_exp, lat_exp, cyc, acc;
    bit          addr_ok, wdata_ok;
    logic [31:0] rdata_exp;
    bit          err_exp;
    timeout   = (waits >= TO);
    acc_exp   = timeout ? TO : waits + 1;
    lat_exp   = 2 + acc_exp;
    rdata_exp = (wr || timeout) ? 32'h0 : model[idx];
    err_exp   = timeout || slverr;
    wait_req  = waits;
    err_req   = slverr;

    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr_map[idx]; cmd_wdata = wdata;
    rsp_ready = 1'b0;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_wdata = $urandom; cmd_addr = $urandom;
    chk("setup_phase", {psel, penable}, 2'b10);
    cyc = 1; acc = 0; addr_ok = 1; wdata_ok = 1;
    while (!rsp_valid && cyc < 60) begin
      @(negedge pclk);
      cyc++;
      if (psel && penable) begin
        acc++;
        if (paddr !== addr_map[idx] || pwrite !== wr) addr_ok = 0;
        if (wr && pwdata !== wdata) wdata_ok = 0;
      end
    end
    chk("rsp_latency", cyc, lat_exp);
    chk("access_cycles", acc, acc_exp);
    chk("addr_stable", addr_ok, 1);
    if (wr) chk("wdata_stable", wdata_ok, 1);
    chk("rsp_rdata", rsp_rdata, rdata_exp);
    chk("rsp_err", rsp_err, err_exp);
    chk("resp_bus_idle", {psel, penable, cmd_ready}, 3'b000);
    for (int i = 0; i < hold; i++) begin
      @(negedge pclk);
      chk("rsp_held", {rsp_valid, cmd_ready, rsp_rdata, rsp_err}, {2'b10, rdata_exp, err_exp});
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
    chk("back_to_idle", {rsp_valid, cmd_ready}, 2'b01);
    if (wr && !timeout) model[idx] = wdata;
  endtask

  initial begin
    addr_map[0] = CTL_ADDR; addr_map[1] = TIMER0_ADDR;
    addr_map[2] = TIMER1_ADDR; addr_map[3] = STAT_ADDR;
    mem[0] = 32'h0; mem[1] = 32'hcafe_1234; mem[2] = 32'h0; mem[3] = 32'h0;
    for (int i = 0; i < 4; i++) model[i] = mem[i];
    wait_req = 0; err_req = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;

    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    chk("reset_outputs", {psel, penable, pwrite, rsp_valid, rsp_err}, 5'b0);
    chk("reset_data", {paddr, pwdata, rsp_rdata}, 96'h0);
    presetn = 1'b1;
    @(negedge pclk);

    do_xfer(0, 1, 0, 0, 0, 0);               // read TIMER0
    do_xfer(1, 2, 32'h1234_5678, 0, 0, 0);   // write TIMER1
    do_xfer(0, 2, 0, 0, 0, 0);               // read back TIMER1
    do_xfer(0, 1, 0, 3, 0, 0);               // three wait states
    do_xfer(0, 2, 0, 100, 0, 0);             // timeout
    do_xfer(0, 1, 0, TO - 1, 0, 0);          // completes on the last allowed cycle
    do_xfer(0, 3, 0, 0, 1, 5);               // slverr, response held 5 cycles

    // Reset during ACCESS
    wait_req = 100; err_req = 0;
    @(negedge pclk);
    cmd_valid = 1; cmd_write = 0; cmd_addr = TIMER0_ADDR;
    @(negedge pclk);
    cmd_valid = 0;
    repeat (3) @(negedge pclk);
    chk("mid_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1 chk("async_reset_bus", {psel, penable, rsp_valid}, 3'b000);
    repeat (2) @(negedge pclk);
    chk("no_rsp_in_reset", rsp_valid, 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("cmd_ready_after_reset", cmd_ready, 1);
    do_xfer(0, 1, 0, 0, 0, 0);

    for (int n = 0; n < 20; n++) begin
      do_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom,
              int'($urandom_range(0, 4)), ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
